// File: rtl/multi_switch_debounce.sv
// multi_switch_debounce: per-channel 2-flop sync + lockout/stable-wait debounce with rise/fall pulses; long-press hold pulses when DEBOUNCE_HOLD_EN is defined
module multi_switch_debounce #(
  parameter int   CHANNELS        = 4,
  parameter int   DEBOUNCE_CYCLES = 12000,
  parameter int   MODE            = 0,
  parameter logic INIT_VAL        = 1'b0,
  parameter int   HOLD_CYCLES     = 12000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] sw_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CHANNELS-1:0] s1, s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= {CHANNELS{INIT_VAL}};
      s2 <= {CHANNELS{INIT_VAL}};
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic q, r, f, take;
    if (MODE == 0) begin : g_lock
      localparam logic [0:0] ARMED = 1'b0, LOCKED = 1'b1;
      logic [0:0] state;
      assign take = state == ARMED && s2[i] != q;
      // re-arm one cycle after the window ends, so accepted edges are DEBOUNCE_CYCLES+1 apart
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          cnt   <= '0;
          state <= ARMED;
        end else if (take) begin
          cnt   <= '0;
          state <= LOCKED;
        end else if (state == LOCKED) begin
          cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
          state <= cnt == LAST ? ARMED : LOCKED;
        end
    end else begin : g_wait
      assign take = s2[i] != q && cnt == LAST;
      always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (s2[i] == q || take) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        q <= INIT_VAL;
        r <= 1'b0;
        f <= 1'b0;
      end else begin
        q <= take ? s2[i] : q;
        r <= take & s2[i];
        f <= take & ~s2[i];
      end
    assign sw_out[i] = q;
    assign rise[i]   = r;
    assign fall[i]   = f;
`ifdef DEBOUNCE_HOLD_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
    logic [HW-1:0] hc;
    logic h;
    // counter parks one past the threshold so the pulse fires once per press
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        hc <= '0;
        h  <= 1'b0;
      end else begin
        h  <= q && !take && hc == HLAST;
        hc <= !q ? '0 : hc == HLAST + 1'b1 ? hc : hc + 1'b1;
      end
    assign hold[i] = h;
`else
    assign hold[i] = 1'b0;
`endif
  end
`ifndef DEBOUNCE_HOLD_EN
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^HOLD_CYCLES;
`endif
endmodule

// File: doc/multi_switch_debounce.md
# multi_switch_debounce

Parametrised multi-channel debouncer for mechanical switches and buttons. It synchronises each raw input, filters bounce with a per-channel cycle counter in either lockout or stable-wait mode, and emits a clean level plus single-cycle rise/fall pulses per channel. It sits between the board I/O pins and the logger control logic. It replaces per-pin single-channel debouncers and gives one instance for a whole switch bank.

## Interface
- `CHANNELS`, 4: number of independent switch channels (≥1).
- `DEBOUNCE_CYCLES`, 12000: debounce window in clocks (≥2). 12000 is ~1 ms at 12 MHz.
- `MODE`, 0: 0 = lockout (accept the first edge, then ignore the input for the window). 1 = stable-wait (accept only after the input has been stable for the full window).
- `INIT_VAL`, 1'b0: reset level of the synchroniser flops and `sw_out`, applied to all channels.
- `HOLD_CYCLES`, 12000000: long-press threshold in clocks. Used only with `DEBOUNCE_HOLD_EN`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `raw_in`  in  CHANNELS  raw, asynchronous switch inputs.
- `sw_out`  out  CHANNELS  debounced level per channel.
- `rise`  out  CHANNELS  one-cycle pulse when `sw_out[i]` goes 0→1.
- `fall`  out  CHANNELS  one-cycle pulse when `sw_out[i]` goes 1→0.
- `hold`  out  CHANNELS  one-cycle long-press pulse. Tied to 0 without `DEBOUNCE_HOLD_EN`.

## Operation
- Reset values:
  - Synchroniser flops and `sw_out` = `INIT_VAL`.
  - `rise`, `fall`, `hold` = 0.
  - All counters = 0; all channels armed/idle.
- Synchroniser: two flops per channel. `s2[i]` is `raw_in[i]` delayed by 2 clocks. All filtering uses `s2`.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1). Counters never wrap.
- MODE 0, per-channel states ARMED and LOCKED:
  - ARMED with `s2 != sw_out`: load `sw_out <= s2`, pulse `rise` or `fall`, clear the counter, go to LOCKED.
  - LOCKED: the counter increments every cycle and `s2` is ignored. When the counter reaches DEBOUNCE_CYCLES-1, return to ARMED.
  - A difference present on the cycle the channel re-arms is accepted on the next cycle.
- MODE 1:
  - While `s2 != sw_out`, the counter increments.
  - Any cycle with `s2 == sw_out` clears the counter, so a bounce back restarts the window.
  - When the counter equals DEBOUNCE_CYCLES-1 and `s2 != sw_out`: `sw_out <= s2`, pulse the edge output, clear the counter.
- `rise[i]`/`fall[i]` are registered. They are high exactly in the first cycle `sw_out[i]` shows the new value. They are never both high.
- Channels are fully independent. Simultaneous edges on several channels are each handled in the same cycle.
- A post-reset input that differs from `INIT_VAL` is debounced and produces a normal edge pulse.
- `rst` asserted mid-window: the channel is forced to its reset state immediately, with no pulse.

## Timing
- MODE 0 latency, `raw_in` change to `sw_out`/pulse: 3 clocks. The minimum spacing between accepted edges on one channel is DEBOUNCE_CYCLES+1 clocks.
- MODE 1 latency: 2 + DEBOUNCE_CYCLES clocks for a clean input. A glitch shorter than DEBOUNCE_CYCLES clocks after synchronisation produces no output change.
- Pulse width is 1 clock for all pulse outputs.

## Configuration
- `DEBOUNCE_HOLD_EN` defined:
  - A per-channel hold counter counts while `sw_out[i]==1`.
  - When it reaches HOLD_CYCLES-1, `hold[i]` pulses once, then the counter saturates with no further pulses.
  - The counter clears when `sw_out[i]` falls or on reset.
  - Counter width is $clog2(HOLD_CYCLES+1).
- `DEBOUNCE_HOLD_EN` not defined: no hold counters are built, and `hold` is constant 0.

## Test plan
Bench parameters: CHANNELS=4, DEBOUNCE_CYCLES=16, HOLD_CYCLES=64, INIT_VAL=0.
- MODE 0, `raw_in[0]` 0→1 clean: `sw_out[0]`=1 and `rise[0]`=1 for one cycle, 3 clocks after the change. A bounce to 0 for 5 clocks afterwards causes no change.
- MODE 1, `raw_in[1]` pulse 1 for 10 clocks: `sw_out[1]` stays 0 and no pulses occur. A pulse held 40 clocks gives `sw_out[1]`=1 exactly 18 clocks after the edge.
- MODE 1, `raw_in[2]` toggled every 8 clocks for 100 clocks, then held at 1: a single `rise[2]` occurs 18 clocks after the last toggle.
- All four `raw_in` 0→1 on the same clock in MODE 0: all four `rise` bits pulse together 3 clocks later.
- `rst` asserted asynchronously mid-window in MODE 1 with count 10: `sw_out`=0 and counters=0 immediately. After release, no pulse until a full new window elapses.
- With `DEBOUNCE_HOLD_EN`, `raw_in[3]` held at 1 for 200 clocks: exactly one `hold[3]` pulse, 64 clocks after `rise[3]`. Without the macro, `hold` stays 0.
